// File: rtl/freq_meter_pkg.sv
// Shared constants for the frequency meter: FSM state encodings and default parameters.
package freq_meter_pkg;

  localparam int unsigned DefGateCycles = 100_000_000;
  localparam int unsigned DefCntW       = 32;
  localparam int unsigned DefSyncStages = 2;

  typedef logic [1:0] fm_state_t;

  localparam fm_state_t ST_IDLE   = 2'd0;
  localparam fm_state_t ST_GATE   = 2'd1;
  localparam fm_state_t ST_REPORT = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level with a registered rising-edge pulse.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed gate window and reports each window.
// Optional macro FREQ_METER_PERIOD_EN adds an edge-to-edge period measurement.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DefGateCycles,
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = DefSyncStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow,
`ifdef FREQ_METER_PERIOD_EN
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
`endif
  output logic             busy
);

  localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sig_in),
    .rise_o(rise)
  );

  fm_state_t        state_q, state_d;
  logic [GateW-1:0] gate_q, gate_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_d = '0;
        acc_d  = '0;
        sat_d  = 1'b0;
        if (enable) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          gate_d  = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else begin
          gate_d = gate_q + 1'b1;
          if (rise) begin
            if (acc_q == CntMax) sat_d = 1'b1;
            else                 acc_d = acc_q + 1'b1;
          end
          // Result is latched on entry to REPORT so the strobe lands in the REPORT cycle.
          if (gate_q == GateLast) begin
            state_d = ST_REPORT;
            gate_d  = '0;
            count_d = acc_d;
            ovf_d   = sat_d;
            valid_d = 1'b1;
          end
        end
      end
      ST_REPORT: begin
        gate_d  = '0;
        acc_d   = '0;
        sat_d   = 1'b0;
        state_d = enable ? ST_GATE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_GATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, period_q;
  logic             seen_q, pvalid_q;

  // Free-running, independent of enable; the first edge after reset only arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      seen_q    <= 1'b0;
      pvalid_q  <= 1'b0;
    end else if (rise) begin
      per_cnt_q <= CNT_W'(1);
      if (seen_q) period_q <= per_cnt_q;
      pvalid_q  <= seen_q;
      seen_q    <= 1'b1;
    end else begin
      if (per_cnt_q != CntMax) per_cnt_q <= per_cnt_q + 1'b1;
      pvalid_q <= 1'b0;
    end
  end

  assign period       = period_q;
  assign period_valid = pvalid_q;
`endif

endmodule
